spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
- Transaction controller that sits directly upstream of the SPI master (`spi`). It feeds the master's byte-level TX handshake and collects the bytes the master returns.
- A host writes N bytes into a TX FIFO and pulses start. The block issues the bytes to the master one at a time, waits for each received byte and stores it in an RX FIFO for the host to read.
- Converts the master's single-byte interface into a multi-byte burst with status.

Parameters:
- DEPTH, 8, entries in each of the TX and RX FIFOs (power of 2, ≥2).
- LEN_W, 4, width of burst length; must satisfy 2^LEN_W > DEPTH.

Ports:
- P_CLK  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_WR_DATA  input  8  host byte to push into TX FIFO.
- i_WR_EN  input  1  push strobe; ignored when o_TX_FULL=1.
- o_TX_FULL  output  1  TX FIFO full.
- i_START  input  1  one-cycle pulse; begin burst of i_LEN bytes.
- i_LEN  input  LEN_W  burst byte count, sampled on i_START.
- o_BUSY  output  1  burst in progress.
- o_DONE  output  1  one-cycle pulse when the last RX byte has been stored.
- o_OVF  output  1  sticky: an RX byte was dropped because the RX FIFO was full.
- i_RD_EN  input  1  pop strobe for RX FIFO; ignored when empty.
- o_RD_DATA  output  8  RX FIFO head (first-word fall-through).
- o_RX_EMPTY  output  1  RX FIFO empty.
- o_TX_DATA  output  8  byte to SPI master (master's i_TX_DATA).
- o_TX_DV  output  1  one-cycle valid to master (master's i_TX_DV).
- i_TX_READY  input  1  master ready for a new byte.
- i_RX_DATA  input  8  byte received by master.
- i_RX_DV  input  1  one-cycle valid for i_RX_DATA.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM=IDLE; both FIFOs emptied (pointers and counts 0).
  - o_TX_DATA=0, o_TX_DV=0, o_BUSY=0, o_DONE=0, o_OVF=0.
  - o_TX_FULL=0, o_RX_EMPTY=1, o_RD_DATA=0.
- Reset asserted mid-burst aborts the burst; no o_DONE is produced.
- FIFOs:
  - Circular buffers with a count register of width clog2(DEPTH)+1.
  - Push and pop in the same cycle are both honoured and the count is unchanged. This holds when full (TX) or empty-with-incoming (RX) provided the operation is legal that cycle.
  - A write while full is dropped silently.
  - A read while empty is a no-op.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, SEND, WAIT_RX, FINISH.
- IDLE:
  - o_BUSY=0.
  - On i_START with i_LEN≠0: latch remaining=i_LEN, clear o_OVF, go to LOAD.
  - i_START with i_LEN=0 is ignored: no BUSY, no DONE.
- LOAD (o_BUSY=1):
  - When i_TX_READY=1 and the TX FIFO is non-empty: register o_TX_DATA=TX head, pop TX FIFO, go to SEND.
  - Otherwise stay. An empty TX FIFO stalls the burst indefinitely; this is not an error.
- SEND:
  - o_TX_DV=1 for exactly this one cycle, with o_TX_DATA stable; next state WAIT_RX.
  - o_TX_DATA holds its value until the next LOAD pop.
- WAIT_RX:
  - On i_RX_DV=1: push i_RX_DATA into the RX FIFO. If the RX FIFO is full and no pop occurs that cycle, drop the byte and set o_OVF.
  - Decrement remaining. If it reaches 0 go to FINISH, else go to LOAD.
- FINISH: o_DONE=1 for one cycle, o_BUSY=0 from this cycle; go to IDLE.
- i_START while o_BUSY=1 is ignored.
- i_RX_DV outside WAIT_RX is ignored: not stored, no count change.
- Latency:
  - i_START at cycle 0 → LOAD at cycle 1.
  - With READY=1 and data available, the pop happens at cycle 1 and o_TX_DV is high at cycle 2.
  - Per byte, the minimum is 3 cycles plus the master's transfer time.
- Host writes to the TX FIFO are allowed during a burst, so the host can refill while the burst runs.
- o_RD_DATA reflects mem[rd_ptr] combinationally from registered state.

Decomposition:
- Shared package (spi_pkg): FSM state localparams (3-bit encoding) and the byte width constant BYTE_W=8.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): wr_en/din/full, rd_en/dout/empty, count; async active-low reset.
  - Instantiated twice: TX and RX.
- The controller holds the FSM, the remaining counter, the o_TX_DATA/o_TX_DV registers and o_OVF.

Test Plan:
- Reset release, no stimulus → o_BUSY=0, o_DONE=0, o_TX_DV=0, o_RX_EMPTY=1, o_TX_FULL=0 held indefinitely.
- Push 0xAE, 0xB5; i_START with i_LEN=2; master model ready and echoing 0x5A then 0xC3 → o_TX_DV pulses twice carrying 0xAE then 0xB5; o_DONE pulses once after the second i_RX_DV; reads return 0x5A then 0xC3; o_OVF=0.
- Push 8 bytes, attempt a ninth write of 0xFF → o_TX_FULL=1, ninth byte absent; burst of 8 transmits only the original 8 in order.
- i_LEN=3 with only 1 byte preloaded → one TX_DV, then stall in LOAD with o_BUSY=1. Push 2 more bytes → burst resumes and finishes with o_DONE.
- Fill the RX FIFO (8 bytes unread), then run a burst of 1 → o_OVF=1, RX contents unchanged. The next i_START clears o_OVF.
- Assert reset during WAIT_RX of a 4-byte burst → all outputs return to reset values immediately, both FIFOs empty, no o_DONE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst controller: byte width and FSM state encoding.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word fall-through head and an occupancy count.
// A push while full is still accepted when a legal pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_din,
    output logic                   o_full,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte burst controller in front of a byte-level SPI master, with TX and RX FIFOs.
//   state   | meaning
//   IDLE    | waiting for a start with non-zero length
//   LOAD    | waiting for master ready and a TX byte, then pops it
//   SEND    | o_TX_DV high for one cycle
//   WAIT_RX | waiting for the master's returned byte
//   FINISH  | o_DONE pulse, back to IDLE
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 4
) (
    input  logic              P_CLK,
    input  logic              reset,
    input  logic [BYTE_W-1:0] i_WR_DATA,
    input  logic              i_WR_EN,
    output logic              o_TX_FULL,
    input  logic              i_START,
    input  logic [LEN_W-1:0]  i_LEN,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_OVF,
    input  logic              i_RD_EN,
    output logic [BYTE_W-1:0] o_RD_DATA,
    output logic              o_RX_EMPTY,
    output logic [BYTE_W-1:0] o_TX_DATA,
    output logic              o_TX_DV,
    input  logic              i_TX_READY,
    input  logic [BYTE_W-1:0] i_RX_DATA,
    input  logic              i_RX_DV
);

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_remaining;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_tx_dv;
    logic                r_ovf;
    logic                w_tx_pop;
    logic                w_rx_push;
    logic                w_start_ok;
    logic                w_tx_empty;
    logic                w_rx_full;
    logic [BYTE_W-1:0]   w_tx_head;
    logic [$clog2(DEPTH):0] w_tx_cnt_unused;
    logic [$clog2(DEPTH):0] w_rx_cnt_unused;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk   (P_CLK),
        .i_rst_n (reset),
        .i_wr_en (i_WR_EN),
        .i_din   (i_WR_DATA),
        .o_full  (o_TX_FULL),
        .i_rd_en (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_count (w_tx_cnt_unused)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk   (P_CLK),
        .i_rst_n (reset),
        .i_wr_en (w_rx_push),
        .i_din   (i_RX_DATA),
        .o_full  (w_rx_full),
        .i_rd_en (i_RD_EN),
        .o_dout  (o_RD_DATA),
        .o_empty (o_RX_EMPTY),
        .o_count (w_rx_cnt_unused)
    );

    assign w_start_ok = (r_state == ST_IDLE) && i_START && (i_LEN != '0);
    assign o_TX_DATA  = r_tx_data;
    assign o_TX_DV    = r_tx_dv;
    assign o_OVF      = r_ovf;

    always_comb begin
        w_next    = r_state;
        w_tx_pop  = 1'b0;
        w_rx_push = 1'b0;
        o_BUSY    = 1'b0;
        o_DONE    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_BUSY = 1'b1;
                if (i_TX_READY && !w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    w_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                o_BUSY = 1'b1;
                w_next = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
                o_BUSY = 1'b1;
                if (i_RX_DV) begin
                    w_rx_push = 1'b1;
                    w_next    = (r_remaining == LEN_W'(1)) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_FINISH: begin
                o_DONE = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge P_CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_tx_data   <= '0;
            r_tx_dv     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tx_dv <= w_tx_pop;
            if (w_tx_pop) r_tx_data <= w_tx_head;
            if (w_start_ok) begin
                r_remaining <= i_LEN;
                r_ovf       <= 1'b0;
            end else if (w_rx_push) begin
                r_remaining <= r_remaining - 1'b1;
                // RX FIFO drops the byte itself; only a same-cycle host pop makes room
                if (w_rx_full && !i_RD_EN) r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: randomized master timing and data against a queue-based model.
module tb_spi_burst_ctrl;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;

    logic             P_CLK = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       i_WR_DATA = '0;
    logic             i_WR_EN = 1'b0;
    logic             o_TX_FULL;
    logic             i_START = 1'b0;
    logic [LEN_W-1:0] i_LEN = '0;
    logic             o_BUSY;
    logic             o_DONE;
    logic             o_OVF;
    logic             i_RD_EN = 1'b0;
    logic [7:0]       o_RD_DATA;
    logic             o_RX_EMPTY;
    logic [7:0]       o_TX_DATA;
    logic             o_TX_DV;
    logic             i_TX_READY = 1'b0;
    logic [7:0]       i_RX_DATA = '0;
    logic             i_RX_DV = 1'b0;

    spi_burst_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .P_CLK      (P_CLK),
        .reset      (reset),
        .i_WR_DATA  (i_WR_DATA),
        .i_WR_EN    (i_WR_EN),
        .o_TX_FULL  (o_TX_FULL),
        .i_START    (i_START),
        .i_LEN      (i_LEN),
        .o_BUSY     (o_BUSY),
        .o_DONE     (o_DONE),
        .o_OVF      (o_OVF),
        .i_RD_EN    (i_RD_EN),
        .o_RD_DATA  (o_RD_DATA),
        .o_RX_EMPTY (o_RX_EMPTY),
        .o_TX_DATA  (o_TX_DATA),
        .o_TX_DV    (o_TX_DV),
        .i_TX_READY (i_TX_READY),
        .i_RX_DATA  (i_RX_DATA),
        .i_RX_DV    (i_RX_DV)
    );

    always #5 P_CLK = ~P_CLK;

    int checks = 0;
    int failures = 0;

    // Model: contents of both FIFOs, burst progress, sticky overflow, pending master reply
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [7:0] resp_q[$];
    bit         in_burst = 1'b0;
    bit         ovf_m = 1'b0;
    bit         final_pend = 1'b0;
    bit         ready_en = 1'b1;
    int         remaining_m = 0;
    int         resp_wait = 0;
    int         txdv_cnt = 0;
    bit         ds;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge P_CLK);
        i_WR_DATA = b;
        i_WR_EN   = 1'b1;
        if (tx_m.size() < DEPTH) tx_m.push_back(b);
        @(negedge P_CLK);
        i_WR_EN = 1'b0;
        chk("tx_full", o_TX_FULL, tx_m.size() == DEPTH);
    endtask

    task automatic start(input int len);
        @(negedge P_CLK);
        i_START = 1'b1;
        i_LEN   = len[LEN_W-1:0];
        if (!in_burst && len != 0) begin
            in_burst    = 1'b1;
            remaining_m = len;
            ovf_m       = 1'b0;
        end
        @(negedge P_CLK);
        i_START = 1'b0;
        chk("busy_after_start", o_BUSY, in_burst);
        chk("ovf_after_start", o_OVF, ovf_m);
    endtask

    task automatic read_one();
        @(negedge P_CLK);
        chk("rx_empty", o_RX_EMPTY, rx_m.size() == 0);
        if (rx_m.size() != 0) chk("rd_data", o_RD_DATA, rx_m[0]);
        i_RD_EN = 1'b1;
        @(negedge P_CLK);
        i_RD_EN = 1'b0;
        if (rx_m.size() != 0) rx_m.delete(0);
    endtask

    // Acts as the SPI master: replies 1..4 cycles after each TX_DV with random readiness
    task automatic run_master(input int max_cyc, input bit stop_on_done, input int stop_txdv,
                              output bit done_seen);
        done_seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            bit         exp_done;
            logic [7:0] d;
            @(negedge P_CLK);
            exp_done   = final_pend;
            final_pend = 1'b0;
            chk("done", o_DONE, exp_done);
            chk("busy", o_BUSY, in_burst && !exp_done);
            if (exp_done) begin
                in_burst  = 1'b0;
                done_seen = 1'b1;
            end
            i_RX_DV = 1'b0;
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    d = (resp_q.size() != 0) ? resp_q.pop_front() : 8'($urandom);
                    i_RX_DV   = 1'b1;
                    i_RX_DATA = d;
                    if (rx_m.size() < DEPTH) rx_m.push_back(d);
                    else ovf_m = 1'b1;
                    remaining_m--;
                    if (remaining_m == 0) final_pend = 1'b1;
                end
            end
            if (o_TX_DV === 1'b1) begin
                txdv_cnt++;
                chk("txdv_has_data", tx_m.size() != 0, 1);
                if (tx_m.size() != 0) chk("tx_data", o_TX_DATA, tx_m.pop_front());
                resp_wait = $urandom_range(1, 4);
            end
            i_TX_READY = ready_en && ($urandom_range(0, 3) != 0);
            if ((stop_on_done && done_seen) || (stop_txdv != 0 && txdv_cnt >= stop_txdv)) break;
        end
        if (stop_on_done) chk("done_within_budget", done_seen, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, o_BUSY, 0);
        chk({tag, "_done"}, o_DONE, 0);
        chk({tag, "_txdv"}, o_TX_DV, 0);
        chk({tag, "_txdata"}, o_TX_DATA, 0);
        chk({tag, "_ovf"}, o_OVF, 0);
        chk({tag, "_txfull"}, o_TX_FULL, 0);
        chk({tag, "_rxempty"}, o_RX_EMPTY, 1);
        chk({tag, "_rddata"}, o_RD_DATA, 0);
    endtask

    initial begin
        int len;
        #2 reset = 1'b0;
        repeat (3) @(negedge P_CLK);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Idle with no stimulus
        run_master(20, 1'b0, 0, ds);
        chk("idle_no_done", ds, 0);
        chk("idle_rx_empty", o_RX_EMPTY, 1);
        chk("idle_tx_full", o_TX_FULL, 0);

        // Two-byte burst with fixed echo bytes
        resp_q = '{8'h5A, 8'hC3};
        push(8'hAE);
        push(8'hB5);
        txdv_cnt = 0;
        start(2);
        run_master(100, 1'b1, 0, ds);
        chk("burst2_txdv_cnt", txdv_cnt, 2);
        chk("burst2_ovf", o_OVF, 0);
        repeat (3) read_one();

        // RX_DV outside WAIT_RX is ignored
        @(negedge P_CLK);
        i_RX_DV   = 1'b1;
        i_RX_DATA = 8'h77;
        @(negedge P_CLK);
        i_RX_DV = 1'b0;
        @(negedge P_CLK);
        chk("stray_rxdv_ignored", o_RX_EMPTY, 1);

        // Zero-length start ignored
        start(0);
        run_master(6, 1'b0, 0, ds);
        chk("len0_no_done", ds, 0);

        // Full TX FIFO, ninth write dropped
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        push(8'hFF);
        txdv_cnt = 0;
        start(8);
        run_master(400, 1'b1, 0, ds);
        chk("burst8_txdv_cnt", txdv_cnt, 8);
        chk("burst8_tx_full", o_TX_FULL, 0);
        repeat (DEPTH + 1) read_one();

        // Stall on empty TX FIFO, then refill during the burst
        push(8'($urandom));
        txdv_cnt = 0;
        start(3);
        run_master(40, 1'b0, 0, ds);
        chk("stall_no_done", ds, 0);
        chk("stall_txdv_cnt", txdv_cnt, 1);
        chk("stall_busy", o_BUSY, 1);
        ready_en   = 1'b0;
        i_TX_READY = 1'b0;
        push(8'($urandom));
        push(8'($urandom));
        ready_en = 1'b1;
        run_master(200, 1'b1, 0, ds);
        chk("stall_resume_txdv_cnt", txdv_cnt, 3);
        repeat (3) read_one();

        // Overflow: RX FIFO full, one more byte dropped, next start clears OVF
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        start(8);
        run_master(400, 1'b1, 0, ds);
        push(8'($urandom));
        start(1);
        run_master(100, 1'b1, 0, ds);
        chk("ovf_set", o_OVF, ovf_m);
        chk("ovf_model_set", ovf_m, 1);
        repeat (DEPTH) read_one();
        chk("ovf_sticky", o_OVF, 1);
        push(8'($urandom));
        start(1);
        run_master(100, 1'b1, 0, ds);
        read_one();

        // Random bursts
        repeat (3) begin
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) push(8'($urandom));
            txdv_cnt = 0;
            start(len);
            run_master(400, 1'b1, 0, ds);
            chk("rand_txdv_cnt", txdv_cnt, len);
            chk("rand_ovf", o_OVF, 0);
            repeat (len + 1) read_one();
        end

        // Reset during WAIT_RX of a 4-byte burst
        for (int i = 0; i < 4; i++) push(8'($urandom));
        txdv_cnt = 0;
        start(4);
        run_master(200, 1'b0, 2, ds);
        chk("pre_reset_txdv_cnt", txdv_cnt, 2);
        @(negedge P_CLK);
        chk("pre_reset_busy", o_BUSY, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        tx_m.delete();
        rx_m.delete();
        in_burst   = 1'b0;
        resp_wait  = 0;
        final_pend = 1'b0;
        ovf_m      = 1'b0;
        i_RX_DV    = 1'b0;
        repeat (3) begin
            @(negedge P_CLK);
            chk("reset_hold_no_done", o_DONE, 0);
        end
        reset = 1'b1;
        run_master(10, 1'b0, 0, ds);
        chk("post_reset_no_done", ds, 0);
        push(8'($urandom));
        start(1);
        run_master(100, 1'b1, 0, ds);
        repeat (2) read_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
